// File: rtl/stack_calc_ctrl.sv
// Stack calculator controller: drives an external synchronous-read stack memory.
// Optional sticky error flag for rejected requests enabled by STACK_CALC_ERR_EN.
module stack_calc_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              iRst,
  input  logic [2:0]        iOp,
  input  logic              iOp_Valid,
  input  logic [DATA_W-1:0] iSwtchs,
  input  logic [DATA_W-1:0] iData_Bus,
  output logic              oCs,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData_Out,
  output logic [DATA_W-1:0] oDVR,
  output logic [ADDR_W-1:0] oDAR,
  output logic              oEmpty,
  output logic              oFull,
  output logic              oBusy,
  output logic              oErr
);

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_TOP   = 3'd4;
  localparam logic [2:0] OP_DEC   = 3'd5;
  localparam logic [2:0] OP_INC   = 3'd6;

  localparam logic [ADDR_W-1:0] A_ONES = '1;
  localparam logic [ADDR_W-1:0] A_ZERO = '0;
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_TWO  = A_ONE + A_ONE;
  localparam logic [DATA_W-1:0] D_ZERO = '0;

`ifdef STACK_CALC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH, S_RDA, S_RDC, S_ARA, S_ARB, S_ARC, S_ARW, S_POPE, S_CLR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] spr_q, spr_d;
  logic [ADDR_W-1:0] dar_q, dar_d;
  logic [DATA_W-1:0] dvr_q, dvr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              err_q, err_d;

  logic              cs, we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] result;
  logic              empty, full, below_two;

  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      spr_q   <= A_ONES;
      dar_q   <= A_ZERO;
      dvr_q   <= D_ZERO;
      addr_q  <= A_ZERO;
      opnd_q  <= D_ZERO;
      op_q    <= 3'd0;
      a_q     <= D_ZERO;
      b_q     <= D_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      spr_q   <= spr_d;
      dar_q   <= dar_d;
      dvr_q   <= dvr_d;
      addr_q  <= addr_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
    end
  end

  assign empty     = (spr_q == A_ONES);
  assign full      = (spr_q == A_ZERO);
  assign below_two = &spr_q[ADDR_W-1:1];
  assign result    = (op_q == OP_SUB) ? (b_q - a_q) : (b_q + a_q);

  always_comb begin
    state_d   = state_q;
    spr_d     = spr_q;
    dar_d     = dar_q;
    dvr_d     = dvr_q;
    addr_d    = addr_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    err_d     = err_q;
    cs        = 1'b0;
    we        = 1'b0;
    mem_addr  = A_ZERO;
    mem_wdata = D_ZERO;
    case (state_q)
      S_IDLE: begin
        if (iOp_Valid) begin
          op_d = iOp;
          case (iOp)
            OP_PUSH: begin
              if (full) err_d = err_q | ERR_EN;
              else begin
                opnd_d  = iSwtchs;
                state_d = S_PUSH;
              end
            end
            OP_POP: begin
              if (empty) err_d = err_q | ERR_EN;
              else if (spr_q == A_ONES - A_ONE) state_d = S_POPE;
              else begin
                addr_d  = spr_q + A_TWO;
                state_d = S_RDA;
              end
            end
            OP_ADD, OP_SUB: begin
              if (below_two) err_d = err_q | ERR_EN;
              else state_d = S_ARA;
            end
            OP_TOP: begin
              if (empty) err_d = err_q | ERR_EN;
              else begin
                addr_d  = spr_q + A_ONE;
                state_d = S_RDA;
              end
            end
            OP_DEC: begin
              addr_d  = dar_q - A_ONE;
              state_d = S_RDA;
            end
            OP_INC: begin
              addr_d  = dar_q + A_ONE;
              state_d = S_RDA;
            end
            default: state_d = S_CLR;
          endcase
        end
      end
      S_PUSH: begin
        cs        = 1'b1;
        we        = 1'b1;
        mem_addr  = spr_q;
        mem_wdata = opnd_q;
        spr_d     = spr_q - A_ONE;
        dar_d     = spr_q;
        dvr_d     = opnd_q;
        state_d   = S_IDLE;
      end
      S_RDA: begin
        cs       = 1'b1;
        mem_addr = addr_q;
        state_d  = S_RDC;
      end
      S_RDC: begin
        dvr_d = iData_Bus;
        dar_d = addr_q;
        if (op_q == OP_POP) spr_d = spr_q + A_ONE;
        state_d = S_IDLE;
      end
      // Arithmetic: A read issued in ARA lands in ARB, B read issued in ARB lands in ARC.
      S_ARA: begin
        cs       = 1'b1;
        mem_addr = spr_q + A_ONE;
        state_d  = S_ARB;
      end
      S_ARB: begin
        cs       = 1'b1;
        mem_addr = spr_q + A_TWO;
        a_d      = iData_Bus;
        state_d  = S_ARC;
      end
      S_ARC: begin
        b_d     = iData_Bus;
        state_d = S_ARW;
      end
      S_ARW: begin
        cs        = 1'b1;
        we        = 1'b1;
        mem_addr  = spr_q + A_TWO;
        mem_wdata = result;
        spr_d     = spr_q + A_ONE;
        dar_d     = spr_q + A_TWO;
        dvr_d     = result;
        state_d   = S_IDLE;
      end
      S_POPE: begin
        spr_d   = A_ONES;
        dar_d   = A_ZERO;
        dvr_d   = D_ZERO;
        state_d = S_IDLE;
      end
      S_CLR: begin
        spr_d   = A_ONES;
        dar_d   = A_ZERO;
        dvr_d   = D_ZERO;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset in a write cycle must keep the memory untouched, so strobes are gated.
  assign oCs       = cs & ~iRst;
  assign oWe       = we & ~iRst;
  assign oAddr     = mem_addr;
  assign oData_Out = mem_wdata;
  assign oDVR      = dvr_q;
  assign oDAR      = dar_q;
  assign oEmpty    = empty;
  assign oFull     = full;
  assign oBusy     = (state_q != S_IDLE);
  assign oErr      = err_q;

endmodule

// File: tb/tb_stack_calc_ctrl.sv
// Scoreboard bench for stack_calc_ctrl: default instance plus a 3-bit-address instance.
module tb_stack_calc_ctrl;

`ifdef STACK_CALC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vld, cs, we, empty, full, busy, err;
  logic [2:0] op;
  logic [7:0] sw, rdata, dout, dvr;
  logic [6:0] addr, dar;

  logic       vld_s, cs_s, we_s, empty_s, full_s, busy_s, err_s;
  logic [2:0] op_s, addr_s, dar_s;
  logic [7:0] sw_s, rdata_s, dout_s, dvr_s;

  stack_calc_ctrl dut (
    .clk(clk), .iRst(rst), .iOp(op), .iOp_Valid(vld), .iSwtchs(sw), .iData_Bus(rdata),
    .oCs(cs), .oWe(we), .oAddr(addr), .oData_Out(dout), .oDVR(dvr), .oDAR(dar),
    .oEmpty(empty), .oFull(full), .oBusy(busy), .oErr(err)
  );

  stack_calc_ctrl #(.DATA_W(8), .ADDR_W(3)) dut_s (
    .clk(clk), .iRst(rst), .iOp(op_s), .iOp_Valid(vld_s), .iSwtchs(sw_s), .iData_Bus(rdata_s),
    .oCs(cs_s), .oWe(we_s), .oAddr(addr_s), .oData_Out(dout_s), .oDVR(dvr_s), .oDAR(dar_s),
    .oEmpty(empty_s), .oFull(full_s), .oBusy(busy_s), .oErr(err_s)
  );

  // Environment memories with one-cycle registered read
  logic [7:0] mem   [0:127];
  logic [7:0] mem_s [0:7];
  int cs_cnt = 0, cs_cnt_s = 0;

  always @(posedge clk) begin
    if (cs && we) mem[addr] <= dout;
    if (cs && !we) rdata <= mem[addr];
    if (cs) cs_cnt <= cs_cnt + 1;
    if (cs_s && we_s) mem_s[addr_s] <= dout_s;
    if (cs_s && !we_s) rdata_s <= mem_s[addr_s];
    if (cs_s) cs_cnt_s <= cs_cnt_s + 1;
  end

  int errors = 0, checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [6:0] m_spr, m_dar;
  logic [7:0] m_dvr;
  logic       m_err;
  logic [7:0] m_mem [0:127];

  typedef struct {
    logic [7:0] dvr;
    logic [6:0] dar;
    int         cyc;
    int         ncs;
    logic       empty, full, err;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    m_spr = 7'h7F; m_dar = 7'h00; m_dvr = 8'h00; m_err = 1'b0;
  endtask

  task automatic model_op(input logic [2:0] o, input logic [7:0] v);
    exp_t e;
    logic rej;
    logic [7:0] a, b;
    int cyc, ncs;
    rej = 1'b0; cyc = 0; ncs = 0;
    case (o)
      3'd0: if (m_spr == 7'h00) rej = 1'b1;
            else begin
              m_mem[m_spr] = v; m_dar = m_spr; m_dvr = v; m_spr = m_spr - 7'd1; cyc = 1; ncs = 1;
            end
      3'd1: if (m_spr == 7'h7F) rej = 1'b1;
            else begin
              m_spr = m_spr + 7'd1;
              if (m_spr == 7'h7F) begin m_dvr = 8'h00; m_dar = 7'h00; cyc = 1; end
              else begin m_dar = m_spr + 7'd1; m_dvr = m_mem[m_dar]; cyc = 2; ncs = 1; end
            end
      3'd2, 3'd3: if (m_spr >= 7'h7E) rej = 1'b1;
            else begin
              a = m_mem[m_spr + 7'd1];
              b = m_mem[m_spr + 7'd2];
              m_dvr = (o == 3'd2) ? b + a : b - a;
              m_dar = m_spr + 7'd2;
              m_mem[m_dar] = m_dvr;
              m_spr = m_spr + 7'd1; cyc = 4; ncs = 3;
            end
      3'd4: if (m_spr == 7'h7F) rej = 1'b1;
            else begin m_dar = m_spr + 7'd1; m_dvr = m_mem[m_dar]; cyc = 2; ncs = 1; end
      3'd5: begin m_dar = m_dar - 7'd1; m_dvr = m_mem[m_dar]; cyc = 2; ncs = 1; end
      3'd6: begin m_dar = m_dar + 7'd1; m_dvr = m_mem[m_dar]; cyc = 2; ncs = 1; end
      default: begin m_spr = 7'h7F; m_dar = 7'h00; m_dvr = 8'h00; m_err = 1'b0; cyc = 1; end
    endcase
    if (rej) m_err = m_err | ERR_EN;
    e.dvr = m_dvr; e.dar = m_dar; e.cyc = cyc; e.ncs = ncs;
    e.empty = (m_spr == 7'h7F); e.full = (m_spr == 7'h00); e.err = m_err;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] v);
    exp_t e;
    int n, cs0;
    string t;
    model_op(o, v);
    @(negedge clk);
    op = o; sw = v; vld = 1'b1; cs0 = cs_cnt;
    @(negedge clk);
    vld = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    t = $sformatf("op%0d", o);
    check_val({t, " busy_cycles"}, n, e.cyc);
    check_val({t, " cs_cycles"}, cs_cnt - cs0, e.ncs);
    check_val({t, " dvr"}, dvr, e.dvr);
    check_val({t, " dar"}, dar, e.dar);
    check_val({t, " empty"}, empty, e.empty);
    check_val({t, " full"}, full, e.full);
    check_val({t, " err"}, err, e.err);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push_small(input logic [7:0] v);
    int n;
    @(negedge clk);
    op_s = 3'd0; sw_s = v; vld_s = 1'b1;
    @(negedge clk);
    vld_s = 1'b0;
    n = 0;
    while (busy_s && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_val("small push busy_cycles", n, (v == 8'hEE) ? 0 : 1);
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 128; i++) begin mem[i] = 8'h00; m_mem[i] = 8'h00; end
    for (int i = 0; i < 8; i++) mem_s[i] = 8'h00;
    rdata = 8'h00; rdata_s = 8'h00;
    rst = 1'b1; vld = 1'b0; op = 3'd0; sw = 8'h00;
    vld_s = 1'b0; op_s = 3'd0; sw_s = 8'h00;
    apply_reset();

    check_val("reset dvr", dvr, 8'h00);
    check_val("reset dar", dar, 7'h00);
    check_val("reset empty", empty, 1'b1);
    check_val("reset full", full, 1'b0);
    check_val("reset busy", busy, 1'b0);
    check_val("reset cs_we", {cs, we}, 2'b00);
    check_val("reset addr_data", {addr, dout}, 15'h0);
    check_val("reset err", err, 1'b0);

    // Small instance: fill to capacity, then one push too many
    for (int i = 0; i < 7; i++) push_small(8'h10 + 8'(i));
    check_val("small full", full_s, 1'b1);
    check_val("small dar", dar_s, 3'd1);
    c0 = cs_cnt_s;
    push_small(8'hEE);
    check_val("small overflow cs", cs_cnt_s - c0, 0);
    check_val("small overflow full", full_s, 1'b1);
    check_val("small overflow dvr", dvr_s, 8'h16);
    check_val("small overflow mem0", mem_s[0], 8'h00);
    check_val("small overflow err", err_s, ERR_EN);

    // Push/push/add
    do_op(3'd0, 8'h12);
    do_op(3'd0, 8'h34);
    check_val("mem7F after push", mem[127], 8'h12);
    check_val("mem7E after push", mem[126], 8'h34);
    do_op(3'd2, 8'h00);
    check_val("mem7F after add", mem[127], 8'h46);

    // Subtraction with wraparound
    apply_reset();
    do_op(3'd0, 8'h05);
    do_op(3'd0, 8'h07);
    do_op(3'd3, 8'h00);
    check_val("mem7F after sub", mem[127], 8'hFE);

    // Rejected pop on empty stack, then clear
    apply_reset();
    do_op(3'd1, 8'h00);
    do_op(3'd7, 8'h00);

    // Reset during arithmetic cycle 3
    apply_reset();
    do_op(3'd0, 8'hAA);
    do_op(3'd0, 8'h55);
    @(negedge clk);
    op = 3'd2; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort busy", busy, 1'b0);
    check_val("abort we", we, 1'b0);
    check_val("abort empty", empty, 1'b1);
    check_val("abort dvr", dvr, 8'h00);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_val("abort mem7F", mem[127], 8'hAA);
    check_val("abort mem7E", mem[126], 8'h55);

    // Reset wins over a simultaneous request
    @(negedge clk);
    rst = 1'b1; vld = 1'b1; op = 3'd0; sw = 8'h77; c0 = cs_cnt;
    @(negedge clk);
    rst = 1'b0; vld = 1'b0;
    @(negedge clk);
    check_val("rst_prio busy", busy, 1'b0);
    check_val("rst_prio empty", empty, 1'b1);
    check_val("rst_prio cs", cs_cnt - c0, 0);

    // Randomised mix, biased towards pushes
    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      o = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      if (o == 3'd7 && $urandom_range(0, 3) != 0) o = 3'd0;
      do_op(o, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 128; i++) begin
      if (mem[i] !== m_mem[i]) check_val($sformatf("final mem[%0d]", i), mem[i], m_mem[i]);
    end
    check_val("final mem7F", mem[127], m_mem[127]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
